// File: rtl/rr_grant_arbiter.sv
// Round-robin req/gnt arbiter: one registered one-hot grant, hold limit, one-cycle gap between grants.
// Latency: req high in cycle k while idle -> gnt high in cycle k+1.
// Backpressure: none; requesters hold req until granted, and a req that drops before arbitration is lost.
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [ID_W-1:0]    timeout_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]     gnt_id_nxt;
  logic                busy_nxt;
  logic                timeout_nxt;
  logic [ID_W-1:0]     timeout_id_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic                owner_req;
  logic                hold_at_limit;
  logic [ID_W-1:0]     ptr_after_owner;

  // Pick the first active request at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // The owner's request level, hold-limit test and post-grant pointer (owner becomes lowest priority).
  always_comb begin
    owner_req       = req[gnt_id];
    hold_at_limit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
    ptr_after_owner = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Next-state and next-output logic; every grant ends through GAP so grants never abut.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = '0;
    gnt_id_nxt     = gnt_id;
    hold_nxt       = hold_cnt;
    ptr_nxt        = ptr;
    timeout_nxt    = 1'b0;
    timeout_id_nxt = timeout_id;
    case (state)
      ST_GRANT: begin
        if (!owner_req) begin
          state_nxt = ST_GAP;
          ptr_nxt   = ptr_after_owner;
        end else if (hold_at_limit) begin
          state_nxt      = ST_GAP;
          ptr_nxt        = ptr_after_owner;
          timeout_nxt    = 1'b1;
          timeout_id_nxt = gnt_id;
        end else begin
          gnt_nxt = gnt;
          // Saturate so an unlimited hold never wraps back to a small count.
          if (hold_cnt != {HOLD_W{1'b1}}) hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        if (win_found) begin
          state_nxt        = ST_GRANT;
          gnt_nxt[win_id]  = 1'b1;
          gnt_id_nxt       = win_id;
          hold_nxt         = HOLD_W'(1);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
    busy_nxt = |gnt_nxt;
  end

  // State and registered outputs; reset drops any grant without a timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      timeout_id <= '0;
      hold_cnt   <= '0;
      ptr        <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      gnt_id     <= gnt_id_nxt;
      busy       <= busy_nxt;
      timeout    <= timeout_nxt;
      timeout_id <= timeout_id_nxt;
      hold_cnt   <= hold_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;
  localparam int N     = 4;
  localparam int MH    = 8;
  localparam int BOUND = N * (MH + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic [1:0]   timeout_id;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the resource, for how long, and who has priority next
  bit m_active;
  int m_id, m_held, m_ptr;
  bit m_to;
  int m_to_id;

  logic [N-1:0] prev_gnt = '0;
  int run_len = 0;
  int wait_cnt [N];

  rr_grant_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One arbitration edge of the reference model.
  task automatic model_step(input logic [N-1:0] r, input logic rs);
    bit found;
    int c;
    if (rs) begin
      m_active = 0; m_id = 0; m_held = 0; m_ptr = 0; m_to = 0; m_to_id = 0;
    end else if (m_active) begin
      m_to = 0;
      if (!r[m_id]) begin
        m_active = 0;
        m_ptr    = (m_id + 1) % N;
      end else if (MH != 0 && m_held == MH) begin
        m_active = 0;
        m_to     = 1;
        m_to_id  = m_id;
        m_ptr    = (m_id + 1) % N;
      end else begin
        m_held++;
      end
    end else begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && r[c]) begin
          found    = 1;
          m_active = 1;
          m_id     = c;
          m_held   = 1;
        end
      end
    end
  endtask

  // Drive req/reset for one cycle, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input logic [N-1:0] r, input logic rs);
    int mx;
    req   = r;
    reset = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    check_eq("gnt", 32'(gnt), m_active ? (32'd1 << m_id) : 32'd0);
    check_eq("gnt_id", 32'(gnt_id), 32'(m_id));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("timeout", 32'(timeout), 32'(m_to));
    if (m_to) check_eq("timeout_id", 32'(timeout_id), 32'(m_to_id));
    check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (!rs) check_eq("rise_without_req", 32'(gnt & ~prev_gnt & ~r), 32'd0);
    if (gnt != '0 && gnt == prev_gnt) run_len++;
    else run_len = (gnt != '0) ? 1 : 0;
    check_eq("hold_len_ok", 32'(run_len <= MH), 32'd1);
    mx = 0;
    for (int i = 0; i < N; i++) begin
      if (!rs && r[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > mx) mx = wait_cnt[i];
    end
    check_eq("starve_ok", 32'(mx <= BOUND), 32'd1);
    prev_gnt = gnt;
  endtask

  initial begin
    int len;
    bit seen_to;
    int next_id;
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    reset = 1'b1;
    req   = '0;

    // single requester
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_timeout_id", 32'(timeout_id), 32'd0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0001, 1'b0);
    check_eq("single_first_gnt", 32'(gnt), 32'h1);
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    check_eq("single_released", 32'(gnt), 32'h0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);

    // contention and rotation from pointer 0
    cycle(4'b0000, 1'b1);
    cycle(4'b0110, 1'b0);
    check_eq("contend_first_id", 32'(gnt_id), 32'd1);
    cycle(4'b0110, 1'b0);
    cycle(4'b0110, 1'b0);
    cycle(4'b0100, 1'b0);
    check_eq("contend_gap", 32'(gnt), 32'h0);
    cycle(4'b0100, 1'b0);
    check_eq("contend_second", 32'(gnt), 32'h4);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // hold limit
    cycle(4'b0000, 1'b1);
    len = 0;
    seen_to = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0100, 1'b0);
      if (timeout) seen_to = 1;
      if (!seen_to && gnt == 4'b0100) len++;
    end
    check_eq("timeout_len", 32'(len), 32'd8);
    check_eq("timeout_seen", 32'(seen_to), 32'd1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // wrap-around after a grant to id 3
    cycle(4'b0000, 1'b1);
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b1001, 1'b0);
    check_eq("wrap_first_id", 32'(gnt_id), 32'd0);
    next_id = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1001, 1'b0);
      if (busy && gnt_id != 2'd0 && next_id < 0) next_id = int'(gnt_id);
    end
    check_eq("wrap_second_id", 32'(next_id), 32'd3);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // reset mid-grant
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_timeout", 32'(timeout), 32'd0);
    cycle(4'b1111, 1'b0);
    check_eq("midrst_first_id", 32'(gnt_id), 32'd0);

    // random soak: requests tend to persist so hold limits and rotation get exercised
    r = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 11) != 0);
        else      r[i] = ($urandom_range(0, 3) == 0);
      end
      cycle(r, ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
Round-robin request/grant arbiter that shares one resource among NUM_REQ requesters using the same req/gnt handshake our assertion IP checks. It grants one requester at a time and holds the grant while that requester keeps req high. A hold limit forcibly revokes a grant after a set number of cycles, and one idle turnaround cycle separates consecutive grants. It sits between the requesting agents and the shared resource, and is the block our bind-based req/gnt assertions attach to.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
MAX_HOLD, 8, maximum consecutive grant cycles before forced revoke; 0 = no limit
ID_W, $clog2(NUM_REQ) (min 1), width of id outputs (derived, do not override)
HOLD_W, $clog2(MAX_HOLD+1) (min 1), hold counter width (derived)

Ports:
clk  in  1  system clock; all logic on posedge clk
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; requester holds high until granted and while using the resource
gnt  out  NUM_REQ  registered grant, one-hot or zero
gnt_id  out  ID_W  index of the current/last granted requester
busy  out  1  high while any gnt bit is high
timeout  out  1  one-cycle pulse when a grant is force-revoked
timeout_id  out  ID_W  index of revoked requester, valid while timeout=1

Behaviour:
- Reset (sampled at posedge, any state): next cycle gnt=0, gnt_id=0, busy=0, timeout=0, timeout_id=0, hold_cnt=0, rr pointer=0, state=IDLE. Reset mid-grant drops gnt on the next edge with no timeout pulse.
- FSM states:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit high.
  - GAP: gnt=0 for exactly one turnaround cycle.
- IDLE or GAP -> GRANT: at the edge ending the cycle, if any req bit is high, choose the winner by scanning from the pointer upward with wrap. Set gnt[winner]=1, gnt_id=winner, hold_cnt=1. If no req bit is high, go to IDLE.
- Latency: req sampled high in cycle k while in IDLE -> gnt high in cycle k+1.
- GRANT, req[gnt_id] low at edge: -> GAP.
- GRANT, req[gnt_id] high and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): stay in GRANT, hold_cnt++.
- GRANT, req[gnt_id] high and MAX_HOLD!=0 and hold_cnt==MAX_HOLD: -> GAP with timeout=1 and timeout_id=gnt_id during the GAP cycle.
- Grant length is therefore never more than MAX_HOLD cycles.
- On every GRANT->GAP transition, pointer = (gnt_id+1) mod NUM_REQ. The just-served requester becomes lowest priority. If it is the only requester, it is re-granted after the GAP cycle.
- hold_cnt saturates; it does not wrap when MAX_HOLD==0.
- gnt_id retains its value in IDLE/GAP.
- Requests from non-granted lines during GRANT are not latched. A req pulse that falls before an arbitration edge is lost.
- busy == |gnt, registered. Invariants: $onehot0(gnt); gnt[i] rises only if req[i] was high in the previous cycle; at least one zero cycle between grants to different ids.
- NUM_REQ=1: single requester, same FSM, ID_W=1, id always 0.

Test Plan:
- Single requester: reset high cycles 0-2, req=0001 cycles 5-7 -> gnt=0001 cycles 6-8, gnt_id=0, busy=1 cycles 6-8, gnt=0 cycle 9, timeout never asserted.
- Contention and rotation: pointer=0, req=0110 held; drop req[1] after 3 grant cycles -> gnt=0010 for 3 cycles, one gap cycle, then gnt=0100, gnt_id=2.
- Timeout: MAX_HOLD=8, req=0100 held 20 cycles -> gnt=0100 for exactly 8 cycles, then gap cycle with timeout=1 and timeout_id=2, then gnt=0100 re-granted.
- Wrap-around: after a grant to id 3 ends, req=1001 -> next grant goes to id 0 (pointer wrapped); the following grant goes to id 3.
- Reset mid-grant: reset pulsed while gnt=0100 -> next cycle gnt=0, busy=0, timeout=0; then req=1111 -> first grant is to id 0.
- Randomised soak: random req for 2000 cycles with bound req/gnt assertions -> $onehot0(gnt) holds, no grant without a prior-cycle req, no grant longer than MAX_HOLD, every continuously held req granted within NUM_REQ*(MAX_HOLD+1) cycles.
